// File: rtl/pc_branch_ctrl.sv
// rtl/pc_branch_ctrl.sv - branch/call decode with return-address stack feeding the program counter
module pc_branch_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 8,
  localparam int SPW  = $clog2(DEPTH + 1),
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [1:0]     op,
  input  logic           cond,
  input  logic [AW-1:0]  target,
  input  logic [AW-1:0]  pc_in,
  output logic           mode,
  output logic [AW-1:0]  write_data,
  output logic [SPW-1:0] sp,
  output logic           stack_full,
  output logic           stack_empty,
  output logic           overflow,
  output logic           underflow
);

  typedef enum logic [1:0] {
    OP_STEP = 2'b00,
    OP_JUMP = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

  logic [AW-1:0]  stack_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic           push_en;
  logic [IW-1:0]  push_idx;
  logic [IW-1:0]  top_idx;
  logic [AW-1:0]  ret_addr;
  logic           full, empty;

  assign full     = (sp_q == SPW'(DEPTH));
  assign empty    = (sp_q == '0);
  assign push_idx = IW'(sp_q);
  assign top_idx  = IW'(sp_q - SPW'(1));
  assign ret_addr = pc_in + AW'(1);

  // Decode is purely combinational so the counter loads on the same edge the stack moves.
  always_comb begin
    mode       = 1'b0;
    write_data = '0;
    sp_d       = sp_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    push_en    = 1'b0;
    if (!rst && en) begin
      case (op_e'(op))
        OP_STEP: ;
        OP_JUMP: begin
          if (cond) begin
            mode       = 1'b1;
            write_data = target;
          end
        end
        OP_CALL: begin
          if (cond) begin
            mode       = 1'b1;
            write_data = target;
            if (full) begin
              ovf_d = 1'b1;
            end else begin
              push_en = 1'b1;
              sp_d    = sp_q + SPW'(1);
            end
          end
        end
        OP_RET: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            mode       = 1'b1;
            write_data = stack_q[top_idx];
            sp_d       = sp_q - SPW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (push_en) begin
        stack_q[push_idx] <= ret_addr;
      end
    end
  end

  assign sp          = sp_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// tb/tb_pc_branch_ctrl.sv - vector table, corner sequences and random run against a queue model
module tb_pc_branch_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = 8;
  localparam int SPW   = $clog2(DEPTH + 1);

  logic           clk = 1'b0;
  logic           rst, en, cond;
  logic [1:0]     op;
  logic [AW-1:0]  target, pc_in;
  logic           mode;
  logic [AW-1:0]  write_data;
  logic [SPW-1:0] sp;
  logic           stack_full, stack_empty, overflow, underflow;

  pc_branch_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .cond(cond), .target(target),
    .pc_in(pc_in), .mode(mode), .write_data(write_data), .sp(sp),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: return stack as a queue, back = top of stack.
  int m_q[$];
  bit m_ovf, m_unf;

  logic           s_mode, s_unf, s_ovf, s_full;
  logic [AW-1:0]  s_wd;
  logic [SPW-1:0] s_sp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit e, input logic [1:0] o, input bit c,
                      input logic [AW-1:0] t, input logic [AW-1:0] p);
    int em, ewd;
    @(negedge clk);
    rst = r; en = e; op = o; cond = c; target = t; pc_in = p;
    #1;
    s_mode = mode; s_wd = write_data; s_sp = sp; s_unf = underflow;
    s_ovf = overflow; s_full = stack_full;
    em = 0; ewd = 0;
    chk("sp", 32'(sp), 32'(m_q.size()));
    chk("stack_full", 32'(stack_full), 32'(m_q.size() == DEPTH));
    chk("stack_empty", 32'(stack_empty), 32'(m_q.size() == 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    if (r) begin
      m_q.delete(); m_ovf = 0; m_unf = 0;
    end else if (e) begin
      if (o == 2'd1 && c) begin
        em = 1; ewd = t;
      end else if (o == 2'd2 && c) begin
        em = 1; ewd = t;
        if (m_q.size() < DEPTH) m_q.push_back((p + 1) % 256);
        else m_ovf = 1;
      end else if (o == 2'd3) begin
        if (m_q.size() > 0) begin
          em = 1; ewd = m_q.pop_back();
        end else m_unf = 1;
      end
    end
    chk("mode", 32'(mode), 32'(em));
    chk("write_data", 32'(write_data), 32'(ewd));
  endtask

  typedef struct {
    bit r; bit e; logic [1:0] o; bit c; logic [7:0] t; logic [7:0] p;
    bit x_mode; logic [7:0] x_wd; int x_sp; bit x_unf;
  } vec_t;

  vec_t vt[$];

  initial begin
    // rst en op c target pc | mode wd sp unf (sp/unf as seen in that cycle)
    vt.push_back('{0,1,2'd0,0,8'h00,8'h00, 0,8'h00,0,0});
    vt.push_back('{0,1,2'd0,0,8'h00,8'h01, 0,8'h00,0,0});
    vt.push_back('{0,1,2'd0,0,8'h00,8'h02, 0,8'h00,0,0});
    vt.push_back('{0,1,2'd1,1,8'h40,8'h03, 1,8'h40,0,0});
    vt.push_back('{0,1,2'd1,0,8'h40,8'h04, 0,8'h00,0,0});
    vt.push_back('{0,1,2'd2,1,8'h10,8'h05, 1,8'h10,0,0});
    vt.push_back('{0,1,2'd2,1,8'h20,8'h12, 1,8'h20,1,0});
    vt.push_back('{0,1,2'd3,0,8'h00,8'h22, 1,8'h13,2,0});
    vt.push_back('{0,1,2'd3,0,8'h00,8'h13, 1,8'h06,1,0});
    vt.push_back('{0,1,2'd2,1,8'h30,8'hFF, 1,8'h30,0,0});
    vt.push_back('{0,1,2'd3,1,8'h00,8'h30, 1,8'h00,1,0});
    vt.push_back('{0,0,2'd2,1,8'h77,8'h33, 0,8'h00,0,0});
    vt.push_back('{0,1,2'd0,0,8'h00,8'h34, 0,8'h00,0,0});
    vt.push_back('{0,1,2'd3,1,8'h00,8'h35, 0,8'h00,0,0});
    vt.push_back('{0,1,2'd1,1,8'h41,8'h36, 1,8'h41,0,1});
    vt.push_back('{0,1,2'd2,1,8'h50,8'h60, 1,8'h50,0,1});
    vt.push_back('{0,1,2'd2,1,8'h51,8'h50, 1,8'h51,1,1});
    vt.push_back('{1,1,2'd3,1,8'h00,8'h51, 0,8'h00,2,1});
    vt.push_back('{0,1,2'd3,1,8'h00,8'h00, 0,8'h00,0,0});
    vt.push_back('{0,1,2'd0,0,8'h00,8'h01, 0,8'h00,0,1});

    rst = 1; en = 0; op = 0; cond = 0; target = 0; pc_in = 0;
    m_ovf = 0; m_unf = 0;
    repeat (2) @(posedge clk);

    foreach (vt[i]) begin
      step(vt[i].r, vt[i].e, vt[i].o, vt[i].c, vt[i].t, vt[i].p);
      chk($sformatf("vec%0d.mode", i), 32'(s_mode), 32'(vt[i].x_mode));
      chk($sformatf("vec%0d.wd", i), 32'(s_wd), 32'(vt[i].x_wd));
      chk($sformatf("vec%0d.sp", i), 32'(s_sp), 32'(vt[i].x_sp));
      chk($sformatf("vec%0d.unf", i), 32'(s_unf), 32'(vt[i].x_unf));
    end

    // Overflow: DEPTH+1 calls, then DEPTH returns in LIFO order.
    step(1, 0, 2'd0, 0, 8'h00, 8'h00);
    for (int i = 0; i <= DEPTH; i++) begin
      step(0, 1, 2'd2, 1, 8'(8'h80 + i), 8'(8'h10 + 2 * i));
      chk("ovf_call.mode", 32'(s_mode), 32'd1);
      chk("ovf_call.wd", 32'(s_wd), 32'(8'h80 + i));
      chk("ovf_call.full", 32'(s_full), 32'(i == DEPTH));
    end
    for (int k = 0; k < DEPTH; k++) begin
      step(0, 1, 2'd3, 0, 8'h00, 8'h00);
      chk("lifo.ovf", 32'(s_ovf), 32'd1);
      chk("lifo.wd", 32'(s_wd), 32'(8'h10 + 2 * (DEPTH - 1 - k) + 1));
    end
    step(0, 1, 2'd3, 0, 8'h00, 8'h00);
    chk("drained.mode", 32'(s_mode), 32'd0);

    // Random run, calls slightly favoured to reach the full boundary.
    for (int n = 0; n < 2000; n++) begin
      int w;
      logic [1:0] o;
      w = $urandom_range(0, 9);
      o = (w < 4) ? 2'd2 : (w < 6) ? 2'd3 : (w < 8) ? 2'd1 : 2'd0;
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), o,
           $urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
